data_monitor: RTL

DATA_MONITOR -- requirements
Module: data_monitor

---
 rtl/data_monitor.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/data_monitor.sv
// Run-length monitor: tracks repeats of the last accepted sample and queues
// run-start / run-end events in a 2-entry FIFO with a sticky drop flag.
module data_monitor #(
  parameter int WIDTH   = 8,
  parameter int CNT_W   = 8,
  parameter int RUN_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             clear,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic             evt_kind,
  output logic [WIDTH-1:0] evt_data,
  output logic [CNT_W-1:0] evt_len,
  output logic [CNT_W-1:0] run_count,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] RUN_LEN_C = CNT_W'(RUN_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {IDLE, TRACK, RUN} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] storage_reg, storage_next;
  logic [CNT_W-1:0] count_reg, count_next, count_inc;

  logic             push;
  logic             push_kind;
  logic [WIDTH-1:0] push_data;
  logic [CNT_W-1:0] push_len;

  assign count_inc = count_reg + CNT_W'(1);

  always_comb begin
    state_next   = state_reg;
    storage_next = storage_reg;
    count_next   = count_reg;
    push         = 1'b0;
    push_kind    = 1'b0;
    push_data    = storage_reg;
    push_len     = count_reg;
    if (din_valid) begin
      if (state_reg == IDLE) begin
        storage_next = din;
        count_next   = CNT_W'(1);
        state_next   = TRACK;
      end else if (din == storage_reg) begin
        // Saturated counter stays put; start fires only on the TRACK->RUN step.
        if (count_reg != CNT_MAX) begin
          count_next = count_inc;
          if (state_reg == TRACK && count_inc == RUN_LEN_C) begin
            push       = 1'b1;
            push_len   = RUN_LEN_C;
            state_next = RUN;
          end
        end
      end else begin
        if (state_reg == RUN) begin
          push      = 1'b1;
          push_kind = 1'b1;
        end
        storage_next = din;
        count_next   = CNT_W'(1);
        state_next   = TRACK;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      storage_reg <= '0;
      count_reg   <= '0;
    end else if (clear) begin
      state_reg   <= IDLE;
      storage_reg <= '0;
      count_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      storage_reg <= storage_next;
      count_reg   <= count_next;
    end
  end

  // Event FIFO: head pointer plus fill level over two entry registers.
  logic             head_reg;
  logic [1:0]       fill_reg, fill_next;
  logic             kind_mem [2];
  logic [WIDTH-1:0] data_mem [2];
  logic [CNT_W-1:0] len_mem  [2];
  logic             overflow_reg;
  logic             pop, full, accept, wr_idx;

  assign pop    = (fill_reg != 2'd0) && evt_ready;
  assign full   = (fill_reg == 2'd2);
  assign accept = push && (!full || pop);
  assign wr_idx = head_reg ^ fill_reg[0];

  always_comb begin
    fill_next = fill_reg;
    case ({accept, pop})
      2'b10:   fill_next = fill_reg + 2'd1;
      2'b01:   fill_next = fill_reg - 2'd1;
      default: fill_next = fill_reg;
    endcase
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          kind_mem[gi] <= 1'b0;
          data_mem[gi] <= '0;
          len_mem[gi]  <= '0;
        end else if (!clear && accept && wr_idx == 1'(gi)) begin
          kind_mem[gi] <= push_kind;
          data_mem[gi] <= push_data;
          len_mem[gi]  <= push_len;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_reg     <= 1'b0;
      fill_reg     <= 2'd0;
      overflow_reg <= 1'b0;
    end else if (clear) begin
      head_reg     <= 1'b0;
      fill_reg     <= 2'd0;
      overflow_reg <= 1'b0;
    end else begin
      head_reg     <= pop ? ~head_reg : head_reg;
      fill_reg     <= fill_next;
      overflow_reg <= overflow_reg | (push && full && !pop);
    end
  end

  // Outputs are masked to zero whenever the FIFO is empty.
  assign evt_valid = (fill_reg != 2'd0);
  assign evt_kind  = evt_valid & kind_mem[head_reg];
  assign evt_data  = evt_valid ? data_mem[head_reg] : '0;
  assign evt_len   = evt_valid ? len_mem[head_reg] : '0;
  assign run_count = count_reg;
  assign overflow  = overflow_reg;

endmodule
